// File: rtl/dds_custom_wave_loader.sv
// rtl/dds_custom_wave_loader.sv - packs the DDS custom-waveform byte stream into 16-bit waveform RAM writes
module dds_custom_wave_loader #(
  parameter int P_CH_NUM = 2,
  parameter int P_ADDR_W = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_dds_custom_channel,
  input  logic [15:0]         i_dds_custom_len,
  input  logic [7:0]          i_dds_custom_data,
  input  logic                i_dds_custom_last,
  input  logic                i_dds_custom_valid,
  output logic                o_wr_en,
  output logic [7:0]          o_wr_ch,
  output logic [P_ADDR_W-1:0] o_wr_addr,
  output logic [15:0]         o_wr_data,
  output logic                o_load_done,
  output logic [7:0]          o_load_ch,
  output logic [15:0]         o_load_samples,
  output logic                o_err,
  output logic [1:0]          o_err_code,
  output logic                o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  // Largest legal payload: two bytes per sample, one full RAM of samples.
  localparam int LEN_MAX = 2 << P_ADDR_W;

  state_t              state;
  logic [7:0]          ch_q;
  logic [15:0]         len_q;
  logic [15:0]         byte_cnt;
  logic [P_ADDR_W-1:0] addr;
  logic                phase;     // 1 = next byte is the low byte of a sample
  logic [7:0]          hi_byte;

  logic [15:0]         cnt_nxt;
  logic                bad_ch;
  logic                bad_len;

  // Next byte count (saturating) and first-beat header checks.
  always_comb begin
    cnt_nxt = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    bad_ch  = int'(i_dds_custom_channel) >= P_CH_NUM;
    bad_len = (i_dds_custom_len == 16'd0) || i_dds_custom_len[0] ||
              (int'(i_dds_custom_len) > LEN_MAX);
  end

  // Packet FSM with registered write, commit and error outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_IDLE;
      ch_q           <= '0;
      len_q          <= '0;
      byte_cnt       <= '0;
      addr           <= '0;
      phase          <= 1'b0;
      hi_byte        <= '0;
      o_wr_en        <= 1'b0;
      o_wr_ch        <= '0;
      o_wr_addr      <= '0;
      o_wr_data      <= '0;
      o_load_done    <= 1'b0;
      o_load_ch      <= '0;
      o_load_samples <= '0;
      o_err          <= 1'b0;
      o_err_code     <= '0;
      o_busy         <= 1'b0;
    end else begin
      o_wr_en     <= 1'b0;
      o_load_done <= 1'b0;
      o_err       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_dds_custom_valid) begin
            ch_q     <= i_dds_custom_channel;
            len_q    <= i_dds_custom_len;
            byte_cnt <= 16'd1;
            addr     <= '0;
            phase    <= 1'b1;
            hi_byte  <= i_dds_custom_data;
            if (bad_ch || bad_len) begin
              o_err      <= 1'b1;
              o_err_code <= bad_ch ? 2'd1 : 2'd2;
              if (!i_dds_custom_last) begin
                state  <= S_DRAIN;
                o_busy <= 1'b1;
              end
            end else if (i_dds_custom_last) begin
              // A one-byte packet can never form a sample.
              o_err      <= 1'b1;
              o_err_code <= 2'd3;
            end else begin
              state  <= S_LOAD;
              o_busy <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (i_dds_custom_valid) begin
            byte_cnt <= cnt_nxt;
            phase    <= ~phase;
            if (phase) begin
              // Bytes beyond the declared length are never written.
              if (cnt_nxt <= len_q) begin
                o_wr_en   <= 1'b1;
                o_wr_ch   <= ch_q;
                o_wr_addr <= addr;
                o_wr_data <= {hi_byte, i_dds_custom_data};
                addr      <= addr + 1'b1;
              end
            end else begin
              hi_byte <= i_dds_custom_data;
            end
            if (i_dds_custom_last) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
              if (cnt_nxt == len_q) begin
                o_load_done    <= 1'b1;
                o_load_ch      <= ch_q;
                o_load_samples <= len_q >> 1;
              end else begin
                o_err      <= 1'b1;
                o_err_code <= 2'd3;
              end
            end
          end else begin
            // Valid dropped mid-packet without last: abort.
            state      <= S_IDLE;
            o_busy     <= 1'b0;
            o_err      <= 1'b1;
            o_err_code <= 2'd3;
          end
        end
        S_DRAIN: begin
          if (!i_dds_custom_valid || i_dds_custom_last) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_custom_wave_loader.sv
// tb/tb_dds_custom_wave_loader.sv - directed self-checking bench for dds_custom_wave_loader
module tb_dds_custom_wave_loader;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_dds_custom_channel = '0;
  logic [15:0] i_dds_custom_len = '0;
  logic [7:0]  i_dds_custom_data = '0;
  logic        i_dds_custom_last = 1'b0;
  logic        i_dds_custom_valid = 1'b0;
  logic        o_wr_en;
  logic [7:0]  o_wr_ch;
  logic [9:0]  o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_load_done;
  logic [7:0]  o_load_ch;
  logic [15:0] o_load_samples;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic        o_busy;

  dds_custom_wave_loader #(.P_CH_NUM(2), .P_ADDR_W(10)) dut (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .i_dds_custom_channel (i_dds_custom_channel),
    .i_dds_custom_len     (i_dds_custom_len),
    .i_dds_custom_data    (i_dds_custom_data),
    .i_dds_custom_last    (i_dds_custom_last),
    .i_dds_custom_valid   (i_dds_custom_valid),
    .o_wr_en              (o_wr_en),
    .o_wr_ch              (o_wr_ch),
    .o_wr_addr            (o_wr_addr),
    .o_wr_data            (o_wr_data),
    .o_load_done          (o_load_done),
    .o_load_ch            (o_load_ch),
    .o_load_samples       (o_load_samples),
    .o_err                (o_err),
    .o_err_code           (o_err_code),
    .o_busy               (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [33:0] wr_q[$];
  int done_n, err_n, done_cyc, err_cyc, last_wr_cyc, busy_first_cyc, busy_last_cyc;
  logic [1:0]  err_code_seen;
  logic [15:0] samples_seen;
  logic [7:0]  load_ch_seen;
  int first_cyc, last_cyc, drop_cyc;

  always @(negedge i_clk) begin
    if (o_wr_en) begin
      wr_q.push_back({o_wr_ch, o_wr_addr, o_wr_data});
      last_wr_cyc = cyc;
    end
    if (o_load_done) begin
      done_n++;
      done_cyc = cyc;
      samples_seen = o_load_samples;
      load_ch_seen = o_load_ch;
    end
    if (o_err) begin
      err_n++;
      err_cyc = cyc;
      err_code_seen = o_err_code;
    end
    if (o_busy) begin
      if (busy_first_cyc < 0) busy_first_cyc = cyc;
      busy_last_cyc = cyc;
    end
    cyc++;
  end

  task automatic clear_sb();
    wr_q.delete();
    done_n = 0; err_n = 0; done_cyc = -1; err_cyc = -1; last_wr_cyc = -1;
    busy_first_cyc = -1; busy_last_cyc = -1;
    err_code_seen = '0; samples_seen = '0; load_ch_seen = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [7:0] ch,
                          input logic [9:0] addr, input logic [15:0] data);
    logic [33:0] e;
    e = 'x;
    if (idx < wr_q.size()) e = wr_q[idx];
    check(tag, {30'd0, e}, {30'd0, ch, addr, data});
  endtask

  task automatic send(input logic [7:0] ch, input logic [15:0] len, input int n,
                      input logic [7:0] base, input logic [7:0] step,
                      input bit with_last, input bit hold);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
      i_dds_custom_valid   = 1'b1;
      i_dds_custom_channel = ch;
      i_dds_custom_len     = len;
      i_dds_custom_data    = base + 8'(k) * step;
      i_dds_custom_last    = with_last && (k == n - 1);
      if (k == 0) first_cyc = cyc;
      if (k == n - 1) last_cyc = cyc;
    end
    if (!hold) begin
      @(posedge i_clk); #1;
      i_dds_custom_valid = 1'b0;
      i_dds_custom_last  = 1'b0;
      drop_cyc = cyc;
      repeat (3) @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    clear_sb();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_wr_en", o_wr_en, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err_code", o_err_code, 0);
    check("rst_load_samples", o_load_samples, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Good packet: ch 1, len 8.
    clear_sb();
    send(8'd1, 16'd8, 8, 8'h01, 8'h01, 1'b1, 1'b0);
    check("t1_nwr", wr_q.size(), 4);
    check_wr("t1_wr0", 0, 8'd1, 10'd0, 16'h0102);
    check_wr("t1_wr1", 1, 8'd1, 10'd1, 16'h0304);
    check_wr("t1_wr2", 2, 8'd1, 10'd2, 16'h0506);
    check_wr("t1_wr3", 3, 8'd1, 10'd3, 16'h0708);
    check("t1_done_n", done_n, 1);
    check("t1_samples", samples_seen, 16'd4);
    check("t1_load_ch", load_ch_seen, 8'd1);
    check("t1_err_n", err_n, 0);
    check("t1_done_lat", done_cyc, last_cyc + 1);
    check("t1_last_wr_with_done", last_wr_cyc, done_cyc);
    check("t1_busy_rise", busy_first_cyc, first_cyc + 1);
    check("t1_busy_fall", busy_last_cyc, last_cyc);

    // Bad channel 5: error at first beat, drain till last.
    clear_sb();
    send(8'd5, 16'd4, 4, 8'h20, 8'h01, 1'b1, 1'b0);
    check("t2_nwr", wr_q.size(), 0);
    check("t2_err_n", err_n, 1);
    check("t2_code", err_code_seen, 2'd1);
    check("t2_err_lat", err_cyc, first_cyc + 1);
    check("t2_busy_fall", busy_last_cyc, last_cyc);
    check("t2_done_n", done_n, 0);

    // Channel equal to P_CH_NUM with an odd length: channel error wins.
    clear_sb();
    send(8'd2, 16'd7, 7, 8'h00, 8'h01, 1'b1, 1'b0);
    check("t2b_code", err_code_seen, 2'd1);
    check("t2b_nwr", wr_q.size(), 0);

    // Odd length.
    clear_sb();
    send(8'd0, 16'd7, 7, 8'h00, 8'h01, 1'b1, 1'b0);
    check("t3a_code", err_code_seen, 2'd2);
    check("t3a_nwr", wr_q.size(), 0);
    check("t3a_err_n", err_n, 1);

    // Length over capacity.
    clear_sb();
    send(8'd0, 16'd2050, 4, 8'h00, 8'h01, 1'b1, 1'b0);
    check("t3b_code", err_code_seen, 2'd2);
    check("t3b_nwr", wr_q.size(), 0);
    check("t3b_err_n", err_n, 1);

    // Single-byte packet with a legal header.
    clear_sb();
    send(8'd0, 16'd2, 1, 8'h55, 8'h01, 1'b1, 1'b0);
    check("t3c_code", err_code_seen, 2'd3);
    check("t3c_nwr", wr_q.size(), 0);
    check("t3c_busy", busy_first_cyc, -1);

    // Early last: len 6, last on 4th byte.
    clear_sb();
    send(8'd1, 16'd6, 4, 8'h10, 8'h01, 1'b1, 1'b0);
    check("t4a_nwr", wr_q.size(), 2);
    check_wr("t4a_wr0", 0, 8'd1, 10'd0, 16'h1011);
    check_wr("t4a_wr1", 1, 8'd1, 10'd1, 16'h1213);
    check("t4a_code", err_code_seen, 2'd3);
    check("t4a_done_n", done_n, 0);

    // Late last: len 4, 6 bytes sent.
    clear_sb();
    send(8'd0, 16'd4, 6, 8'h30, 8'h01, 1'b1, 1'b0);
    check("t4b_nwr", wr_q.size(), 2);
    check_wr("t4b_wr1", 1, 8'd0, 10'd1, 16'h3233);
    check("t4b_code", err_code_seen, 2'd3);
    check("t4b_err_n", err_n, 1);
    check("t4b_done_n", done_n, 0);

    // Abort: valid drops after 3 bytes of len 8.
    clear_sb();
    send(8'd0, 16'd8, 3, 8'h40, 8'h01, 1'b0, 1'b0);
    check("t5_nwr", wr_q.size(), 1);
    check_wr("t5_wr0", 0, 8'd0, 10'd0, 16'h4041);
    check("t5_code", err_code_seen, 2'd3);
    check("t5_err_lat", err_cyc, drop_cyc + 1);
    check("t5_done_n", done_n, 0);

    // Recovery packet after abort.
    clear_sb();
    send(8'd0, 16'd2, 2, 8'hAA, 8'h11, 1'b1, 1'b0);
    check("t5b_nwr", wr_q.size(), 1);
    check_wr("t5b_wr0", 0, 8'd0, 10'd0, 16'hAABB);
    check("t5b_done_n", done_n, 1);
    check("t5b_samples", samples_seen, 16'd1);
    check("t5b_err_n", err_n, 0);

    // Full-capacity packet: len 2048 fills addresses 0..1023.
    clear_sb();
    send(8'd1, 16'd2048, 2048, 8'h00, 8'h01, 1'b1, 1'b0);
    check("tmax_nwr", wr_q.size(), 1024);
    check_wr("tmax_wr_last", 1023, 8'd1, 10'd1023, 16'hFEFF);
    check("tmax_samples", samples_seen, 16'd1024);
    check("tmax_err_n", err_n, 0);

    // Reset mid-LOAD after two writes.
    clear_sb();
    send(8'd1, 16'd8, 5, 8'h61, 8'h01, 1'b0, 1'b1);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    i_dds_custom_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("t6_pre_nwr", wr_q.size(), 2);
    check("t6_wr_en", o_wr_en, 0);
    check("t6_wr_ch", o_wr_ch, 0);
    check("t6_wr_addr", o_wr_addr, 0);
    check("t6_wr_data", o_wr_data, 0);
    check("t6_busy", o_busy, 0);
    check("t6_load_ch", o_load_ch, 0);
    check("t6_load_samples", o_load_samples, 0);
    check("t6_err_code", o_err_code, 0);
    check("t6_done_err", {o_load_done, o_err}, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    clear_sb();
    send(8'd1, 16'd4, 4, 8'hC0, 8'h01, 1'b1, 1'b0);
    check("t6b_nwr", wr_q.size(), 2);
    check_wr("t6b_wr0", 0, 8'd1, 10'd0, 16'hC0C1);
    check_wr("t6b_wr1", 1, 8'd1, 10'd1, 16'hC2C3);
    check("t6b_done_n", done_n, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dds_custom_wave_loader.md
# dds_custom_wave_loader

Consumes the DDS custom-waveform byte stream produced by the UDP type splitter (channel, payload length, data, last, valid) and writes it into the per-channel DDS waveform RAM as 16-bit samples. It validates the channel and length, then emits write strobes and a commit pulse. On a bad packet it emits an error code and writes nothing further. It sits between the UDP type splitter and the DDS waveform memories.

## Interface
- P_CH_NUM, 2: number of DDS channels; legal channel indices are 0..P_CH_NUM-1.
- P_ADDR_W, 10: waveform RAM address width; capacity is 2^P_ADDR_W samples per channel.
- i_clk  in  1  system clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_dds_custom_channel  in  8  target channel; sampled on the first valid beat.
- i_dds_custom_len  in  16  payload byte count; sampled on the first valid beat.
- i_dds_custom_data  in  8  payload byte; high byte of each sample first.
- i_dds_custom_last  in  1  marks the final payload byte; qualified by valid.
- i_dds_custom_valid  in  1  byte qualifier; held high for the whole packet, no gaps.
- o_wr_en  out  1  waveform RAM write strobe.
- o_wr_ch  out  8  channel of the current write.
- o_wr_addr  out  P_ADDR_W  sample address; starts at 0 for each packet.
- o_wr_data  out  16  sample {high byte, low byte}.
- o_load_done  out  1  one-cycle pulse when a packet is committed.
- o_load_ch  out  8  channel of the last commit; held until the next commit.
- o_load_samples  out  16  sample count of the last commit (len/2); held.
- o_err  out  1  one-cycle error pulse.
- o_err_code  out  2  1 = bad channel, 2 = bad length, 3 = length mismatch or abort; held until the next error.
- o_busy  out  1  high while in LOAD or DRAIN.

## Operation
- States: IDLE, LOAD, DRAIN.
- IDLE, on a valid beat (first byte of a packet):
  - Latch channel and len. Clear the byte counter and address.
  - Set the phase bit to low-byte-next and store the byte as the high byte.
- Checks at that first beat, in priority order:
  - Channel ≥ P_CH_NUM → error code 1.
  - len == 0, len odd, or len > 2·2^P_ADDR_W → error code 2.
  - Either error → DRAIN if last is not set on this beat, otherwise stay in IDLE.
  - No error → LOAD. If last is also set on this beat (1-byte packet), raise error code 3 and stay in IDLE.
- LOAD, per valid beat:
  - Increment the byte counter (16-bit, saturating).
  - Toggle the phase bit. On a low-byte beat, issue a write of {held high byte, byte} at the current address, then increment the address.
  - Once the byte count exceeds len, suppress further writes.
- LOAD, last beat:
  - If the total byte count equals len → pulse o_load_done; o_load_ch = channel, o_load_samples = len>>1. Go to IDLE.
  - Otherwise → error code 3, go to IDLE.
- LOAD, valid falls with no last → abort: error code 3, go to IDLE, no done pulse.
- DRAIN: discard bytes. Exit to IDLE on a last beat or when valid drops. No further error pulse.
- Writes already issued before an error are not rolled back. Consumers must treat RAM content as valid only after o_load_done.
- Reset at any time: go to IDLE, clear counters and phase.
  - o_wr_en, o_load_done, o_err, o_busy = 0.
  - o_wr_ch, o_wr_addr, o_wr_data, o_load_ch, o_load_samples, o_err_code = 0.
- Address never wraps: the len limit guarantees the address stays ≤ 2^P_ADDR_W−1.

## Timing
- All outputs are registered.
- The write for a low-byte beat at cycle T appears at T+1: o_wr_en high for exactly one cycle.
- o_load_done and o_err assert at T+1 after the deciding beat (last beat, first beat, or the cycle valid was sampled low).
- For a good packet, the final o_wr_en and o_load_done are in the same cycle.
- o_busy rises at T+1 after the first beat and falls in the same cycle as done/err, or at DRAIN exit.
- Back-to-back packets: a new first beat is accepted in the cycle after the last beat (valid low for ≥1 cycle between packets, as guaranteed upstream).
- Throughput: one byte per cycle; one write every two cycles.

## Test plan
- Channel 1, len 8, bytes 01 02 03 04 05 06 07 08 → writes addr 0..3 data 0102, 0304, 0506, 0708 on ch 1; o_load_done with o_load_samples = 4; o_err stays 0.
- Channel 5 (P_CH_NUM=2), len 4, 4 bytes → no o_wr_en; o_err pulse at T+1 after first beat with o_err_code = 1; o_busy until last.
- len 7 on channel 0 → o_err_code = 2, no writes. len 2050 (P_ADDR_W=10) → o_err_code = 2.
- len 6 but last on 4th byte → two writes, then o_err_code = 3, no o_load_done. len 4 with 6 bytes sent → two writes only, then o_err_code = 3.
- valid drops after 3 bytes of a len 8 packet, no last → one write (addr 0), o_err_code = 3; the next packet (ch 0, len 2, AA BB) writes AABB at addr 0 and pulses done.
- Assert i_rst mid-LOAD after 2 writes → all outputs 0 the next cycle; the following good packet starts at addr 0.
